// File: rtl/seqdiv_pkg.sv
// Shared constants for the seqdiv radix-2 restoring divider: datapath width,
// FSM state encodings and the quotient returned on divide-by-zero.
package seqdiv_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/seqdiv_div_step.sv
// One combinational restoring-division iteration: shift {P,Q} left by one,
// trial-subtract D from P and keep the difference when it does not borrow.
module div_step
  import seqdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_p,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_p_sh;
  logic [WIDTH:0] w_diff;

  assign w_p_sh = {i_p, i_q[WIDTH-1]};
  // Top bit of the extended difference is the borrow; P < D keeps the result in WIDTH bits.
  assign w_diff = w_p_sh - {1'b0, i_d};
  assign o_p    = w_diff[WIDTH] ? w_p_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_q    = {i_q[WIDTH-2:0], ~w_diff[WIDTH]};

endmodule

// File: rtl/seqdiv.sv
// Multicycle divider: CTRL loads operands, 32 restoring steps, then a fix-up cycle.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient).
//
// state | meaning
// IDLE  | waiting for CTRL
// RUN   | one restoring iteration per cycle, 32 cycles
// FIX   | sign correction, results and ready written
// DONE  | one cycle after ready, returns to IDLE
module seqdiv
  import seqdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             CTRL,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             exception,
  output logic             busy
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_ready;
  logic             r_exception;
  logic             r_busy;

  logic             w_dz;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic [WIDTH-1:0] w_p_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_dz = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Iterate on magnitudes; the most negative value maps onto itself, which is correct unsigned.
  assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_q_fin   = r_neg_q ? -r_q : r_q;
  assign w_r_fin   = r_neg_r ? -r_p : r_p;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (CTRL) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_fin   = r_q;
  assign w_r_fin   = r_p;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p (r_p),
    .i_q (r_q),
    .i_d (r_d),
    .o_p (w_p_nxt),
    .o_q (w_q_nxt)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_ready     <= 1'b0;
      r_exception <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (CTRL) begin
        // Divide-by-zero parks the raw dividend in Q and goes straight to FIX.
        r_state <= w_dz ? ST_FIX : ST_RUN;
        r_count <= '0;
        r_p     <= '0;
        r_q     <= w_dz ? dividend : w_dvd_mag;
        r_d     <= w_dvs_mag;
        r_dz    <= w_dz;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_RUN: begin
            r_p     <= w_p_nxt;
            r_q     <= w_q_nxt;
            r_count <= r_count + CNT_ONE;
            if (r_count == LAST_STEP) r_state <= ST_FIX;
          end
          ST_FIX: begin
            r_quotient  <= r_dz ? DZ_QUOTIENT : w_q_fin;
            r_remainder <= r_dz ? r_q : w_r_fin;
            r_exception <= r_dz;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign ready     = r_ready;
  assign exception = r_exception;
  assign busy      = r_busy;

endmodule
